// File: rtl/mbs_bus_arbiter.sv
// Round-robin arbiter and single-outstanding transfer sequencer for the shared system bus.
// Latency: grant/bus_valid one edge after request, ack/err one edge after bus_ready or timeout, idle one cycle after.
// Backpressure: slave stalls with bus_ready=0 for up to TIMEOUT cycles; masters hold m_req until ack/err.
module mbs_bus_arbiter #(
  parameter int NUM_MASTERS = 3,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT     = 15
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_MASTERS-1:0]        m_req,
  input  logic [NUM_MASTERS-1:0]        m_we,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
  output logic [NUM_MASTERS-1:0]        m_gnt,
  output logic [NUM_MASTERS-1:0]        m_ack,
  output logic [NUM_MASTERS-1:0]        m_err,
  output logic [DATA_W-1:0]             m_rdata,
  output logic                          bus_valid,
  output logic                          bus_we,
  output logic [ADDR_W-1:0]             bus_addr,
  output logic [DATA_W-1:0]             bus_wdata,
  input  logic [DATA_W-1:0]             bus_rdata,
  input  logic                          bus_ready,
  output logic                          busy
);

  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] PTR_RST  = IDX_W'(NUM_MASTERS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [CNT_W-1:0] cnt;
  logic             win_vld;
  logic [IDX_W-1:0] win_idx;

  // Pick the first requester after the last-served master, wrapping around.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      if (!win_vld && m_req[(int'(ptr) + k) % NUM_MASTERS]) begin
        win_vld = 1'b1;
        win_idx = IDX_W'((int'(ptr) + k) % NUM_MASTERS);
      end
    end
  end

  // Transfer sequencer: issue the winner's transfer, wait for ready or timeout, pulse the response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= PTR_RST;
      cnt       <= '0;
      m_gnt     <= '0;
      m_ack     <= '0;
      m_err     <= '0;
      m_rdata   <= '0;
      bus_valid <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      busy      <= 1'b0;
    end else begin
      // Response pulses last exactly the one RESP cycle.
      m_ack <= '0;
      m_err <= '0;
      case (state)
        IDLE: begin
          if (win_vld) begin
            ptr       <= win_idx;
            m_gnt     <= NUM_MASTERS'(1) << win_idx;
            bus_valid <= 1'b1;
            bus_we    <= m_we[win_idx];
            bus_addr  <= m_addr[win_idx*ADDR_W +: ADDR_W];
            bus_wdata <= m_wdata[win_idx*DATA_W +: DATA_W];
            cnt       <= '0;
            busy      <= 1'b1;
            state     <= XFER;
          end
        end
        XFER: begin
          if (bus_ready) begin
            // Writes leave the last read data visible.
            if (!bus_we) begin
              m_rdata <= bus_rdata;
            end
            bus_valid <= 1'b0;
            m_ack     <= m_gnt;
            state     <= RESP;
          end else if (cnt == CNT_LAST) begin
            bus_valid <= 1'b0;
            m_err     <= m_gnt;
            state     <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          // No arbitration here: the master updates m_req while it sees ack/err.
          m_gnt <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          m_gnt     <= '0;
          bus_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mbs_bus_arbiter.sv
// Bench for the shared-bus arbiter: directed scenarios then random transfers against a transaction-level model.
// Latency: inputs driven 1 time unit after each rising edge, outputs observed at the same point.
// Backpressure: slave readiness delay chosen per transfer, including never-ready timeouts.
module tb_mbs_bus_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 15;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    m_req;
  logic [N-1:0]    m_we;
  logic [N*AW-1:0] m_addr;
  logic [N*DW-1:0] m_wdata;
  logic [N-1:0]    m_gnt;
  logic [N-1:0]    m_ack;
  logic [N-1:0]    m_err;
  logic [DW-1:0]   m_rdata;
  logic            bus_valid;
  logic            bus_we;
  logic [AW-1:0]   bus_addr;
  logic [DW-1:0]   bus_wdata;
  logic [DW-1:0]   bus_rdata;
  logic            bus_ready;
  logic            busy;

  mbs_bus_arbiter #(
    .NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_gnt(m_gnt), .m_ack(m_ack), .m_err(m_err), .m_rdata(m_rdata),
    .bus_valid(bus_valid), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ready(bus_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int            n_assert = 0;
  int            n_fail   = 0;
  int            cyc_n    = 0;
  int            last     = N - 1;
  int            g_cyc    = 0;
  logic [N-1:0]  g_obs;
  logic [DW-1:0] exp_rdata;
  int            rr_order [8] = '{0, 1, 2, 0, 1, 2, 0, 2};

  task automatic cyc();
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference arbitration: first requester after the last-served master, in circular order.
  function automatic int pick(input logic [N-1:0] r, input int lst);
    for (int k = 1; k <= N; k++) begin
      if (r[(lst + k) % N]) return (lst + k) % N;
    end
    return -1;
  endfunction

  task automatic scramble();
    m_we = N'($urandom);
    for (int i = 0; i < N; i++) begin
      m_addr[i*AW +: AW]  = $urandom;
      m_wdata[i*DW +: DW] = $urandom;
    end
  endtask

  // One complete transaction from IDLE with m_req already applied; d is the XFER cycle
  // in which the slave is ready (negative = never). nreq is presented while ack/err is seen.
  task automatic run_xfer(input int d, input logic [DW-1:0] rd, input logic [N-1:0] nreq);
    int            w;
    logic [AW-1:0] ea;
    logic [DW-1:0] ewd;
    logic          ewe;
    logic [N-1:0]  eg;
    w = pick(m_req, last);
    if (w < 0) w = 0;
    ea  = m_addr[w*AW +: AW];
    ewd = m_wdata[w*DW +: DW];
    ewe = m_we[w];
    eg  = N'(1) << w;
    cyc();
    g_cyc = cyc_n;
    g_obs = m_gnt;
    chk("issue_gnt", m_gnt, eg);
    chk("issue_valid", bus_valid, 1);
    chk("issue_addr", bus_addr, ea);
    chk("issue_we", bus_we, ewe);
    chk("issue_wdata", bus_wdata, ewd);
    chk("issue_busy", busy, 1);
    chk("issue_resp", {m_ack, m_err}, 0);
    scramble();
    for (int k = 0; k < TO; k++) begin
      bus_ready = (k == d);
      bus_rdata = (k == d) ? rd : $urandom;
      cyc();
      if (k == d) begin
        if (!ewe) exp_rdata = rd;
        chk("ack", m_ack, eg);
        chk("ack_no_err", m_err, 0);
        chk("ack_rdata", m_rdata, exp_rdata);
        chk("ack_valid_low", bus_valid, 0);
        chk("ack_gnt", m_gnt, eg);
        break;
      end else if (k == TO - 1) begin
        chk("tmo_err", m_err, eg);
        chk("tmo_no_ack", m_ack, 0);
        chk("tmo_rdata", m_rdata, exp_rdata);
        chk("tmo_valid_low", bus_valid, 0);
      end else begin
        chk("wait_valid", bus_valid, 1);
        chk("wait_addr", bus_addr, ea);
        chk("wait_gnt", m_gnt, eg);
        chk("wait_resp", {m_ack, m_err}, 0);
      end
    end
    bus_ready = 1'($urandom_range(0, 1));
    m_req     = nreq;
    last      = w;
    cyc();
    chk("done_gnt", m_gnt, 0);
    chk("done_resp", {m_ack, m_err}, 0);
    chk("done_busy", busy, 0);
    chk("done_valid", bus_valid, 0);
    chk("done_rdata", m_rdata, exp_rdata);
    bus_ready = 1'($urandom_range(0, 1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] nr;
    int           prev;
    int           d;
    m_req     = '0;
    m_we      = '0;
    m_addr    = '0;
    m_wdata   = '0;
    bus_ready = 1'b0;
    bus_rdata = '0;
    prev      = 0;

    // Reset, then idle with no requests.
    rst = 1'b1;
    repeat (2) cyc();
    rst       = 1'b0;
    exp_rdata = '0;
    last      = N - 1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("idle_ctrl", {m_gnt, m_ack, m_err, bus_valid, bus_we, busy}, 0);
    end
    chk("idle_addr", bus_addr, 0);
    chk("idle_wdata", bus_wdata, 0);
    chk("idle_rdata", m_rdata, 0);

    // All masters requesting: rotation 0,1,2,... then 3'b101 after serving 0 goes to 2.
    scramble();
    m_req = 3'b111;
    for (int i = 0; i < 8; i++) begin
      nr = (i == 6) ? 3'b101 : ((i == 7) ? 3'b000 : 3'b111);
      run_xfer(0, $urandom, nr);
      chk("rr_order", g_obs, N'(1) << rr_order[i]);
      if (i > 0) chk("rr_spacing", g_cyc - prev, 3);
      prev = g_cyc;
    end

    // Single read from master 1, slave ready in the third XFER cycle.
    m_addr[1*AW +: AW] = 32'h0000_1000;
    m_we[1]            = 1'b0;
    m_req              = 3'b010;
    run_xfer(2, 32'hDEAD_BEEF, 3'b000);
    chk("read_gnt", g_obs, 3'b010);
    chk("read_rdata", m_rdata, 32'hDEAD_BEEF);

    // Write from master 2; read data must be left alone.
    m_we[2]             = 1'b1;
    m_addr[2*AW +: AW]  = 32'h0000_0020;
    m_wdata[2*DW +: DW] = 32'h1234_5678;
    m_req               = 3'b100;
    run_xfer(1, $urandom, 3'b000);
    chk("write_gnt", g_obs, 3'b100);
    chk("write_rdata_kept", m_rdata, 32'hDEAD_BEEF);

    // Slave never ready: error after TIMEOUT cycles of bus_valid.
    m_req = 3'b001;
    run_xfer(-1, 32'h0, 3'b000);
    chk("tmo_gnt", g_obs, 3'b001);
    chk("tmo_rdata_kept", m_rdata, 32'hDEAD_BEEF);

    // Reset during the 4th XFER cycle of a master-0 transfer.
    m_req = 3'b001;
    cyc();
    chk("rstx_gnt", m_gnt, 3'b001);
    bus_ready = 1'b0;
    repeat (3) cyc();
    chk("rstx_valid_before", bus_valid, 1);
    rst = 1'b1;
    cyc();
    chk("rstx_ctrl", {m_gnt, m_ack, m_err, bus_valid, busy}, 0);
    chk("rstx_rdata", m_rdata, 0);
    rst       = 1'b0;
    exp_rdata = '0;
    last      = N - 1;
    m_req     = 3'b011;
    nr        = 3'b010;
    run_xfer(0, $urandom, nr);
    chk("rstx_first_gnt", g_obs, 3'b001);

    // Random transfers with changing requests and slave delays.
    for (int i = 0; i < 40; i++) begin
      do nr = N'($urandom); while (nr == '0);
      d = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 5));
      run_xfer(d, $urandom, nr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
